// File: rtl/io_page_pkg.sv
// Shared definitions for the 0x80 I/O page: register addresses, the scroll
// sequencer state type and the message index wrap helper.
package io_page_pkg;

  localparam logic [7:0] SS0_ADDR   = 8'd0;
  localparam logic [7:0] SS1_ADDR   = 8'd1;
  localparam logic [7:0] SS2_ADDR   = 8'd2;
  localparam logic [7:0] SS3_ADDR   = 8'd3;
  localparam logic [7:0] SS4_ADDR   = 8'd4;
  localparam logic [7:0] SS5_ADDR   = 8'd5;
  localparam logic [7:0] SS6_ADDR   = 8'd6;
  localparam logic [7:0] SS7_ADDR   = 8'd7;
  localparam logic [7:0] LEFT_ADDR  = 8'd8;
  localparam logic [7:0] RIGHT_ADDR = 8'd9;
  localparam logic [7:0] PB_ADDR    = 8'd10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WRITE     = 3'd2,
    S_RELEASE   = 3'd3,
    S_WAIT_TICK = 3'd4
  } scroll_state_t;

  // offset+7-idx stays below len+7, so four conditional subtractions cover
  // every legal length down to 2 without a real modulo.
  function automatic logic [4:0] wrap_index(input logic [5:0] sum,
                                            input logic [5:0] len);
    logic [5:0] v;
    v = sum;
    for (int i = 0; i < 4; i++) begin
      if (v >= len) v = v - len;
    end
    return v[4:0];
  endfunction

endpackage

// File: rtl/io_msg_buffer.sv
// Message register file: one synchronous write port, one combinational read
// port, cleared by reset. Writes beyond the message length are dropped.
module io_msg_buffer
  import io_page_pkg::*;
#(
  parameter int MSG_LEN = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_we,
  input  logic [4:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [4:0] i_raddr,
  output logic [7:0] o_rdata
);

  localparam logic [5:0] LEN6 = 6'(MSG_LEN);

  // Full 32-entry array keeps the 5-bit index exact; entries at or above
  // MSG_LEN are never written and stay at zero.
  logic [7:0] r_mem [32];
  logic       w_wr_ok;

  assign w_wr_ok = i_we && ({1'b0, i_waddr} < LEN6);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem <= '{default: '0};
    end else if (w_wr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/io_scroll_sequencer.sv
// Bus-master that scrolls a stored message across the eight 7-seg digits,
// one nine-write burst per frame, then waits FRAME_TICKS before advancing.
module io_scroll_sequencer
  import io_page_pkg::*;
#(
  parameter int MSG_LEN     = 16,
  parameter int FRAME_TICKS = 12_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          msg_we,
  input  logic [4:0]    msg_waddr,
  input  logic [7:0]    msg_wdata,
  output logic          bus_req,
  input  logic          bus_gnt,
  output logic [7:0]    io_addr,
  output logic [7:0]    io_din,
  output logic          io_read_en,
  output logic          busy,
  output logic [4:0]    offset,
  output scroll_state_t dbg_state
);

  localparam int            CNT_W    = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);
  localparam logic [4:0]    OFF_LAST = 5'(MSG_LEN - 1);
  localparam logic [5:0]    LEN6     = 6'(MSG_LEN);
  localparam logic [3:0]    IDX_LAST = 4'd8;

  scroll_state_t    r_state, w_next_state;
  logic [3:0]       r_idx, w_next_idx;
  logic [4:0]       r_offset, w_next_offset;
  logic [CNT_W-1:0] r_cnt, w_next_cnt;

  logic [5:0] w_sum;
  logic [4:0] w_raddr;
  logic [7:0] w_rdata;

  io_msg_buffer #(
    .MSG_LEN(MSG_LEN)
  ) u_buf (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_we   (msg_we),
    .i_waddr(msg_waddr),
    .i_wdata(msg_wdata),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  // Digit idx shows msg[offset+7-idx]; ss7 is leftmost and shows msg[offset].
  assign w_sum   = {1'b0, r_offset} + 6'd7 - {2'b00, r_idx};
  assign w_raddr = wrap_index(w_sum, LEN6);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_offset <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_next_state;
      r_idx    <= w_next_idx;
      r_offset <= w_next_offset;
      r_cnt    <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_idx    = r_idx;
    w_next_offset = r_offset;
    w_next_cnt    = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_next_cnt = '0;
        w_next_idx = '0;
        if (enable) w_next_state = S_REQ;
      end
      S_REQ: begin
        w_next_idx = '0;
        if (bus_gnt)      w_next_state = S_WRITE;
        else if (!enable) w_next_state = S_IDLE;
      end
      S_WRITE: begin
        // Losing the grant restarts the whole burst; enable is not consulted.
        if (!bus_gnt) begin
          w_next_state = S_REQ;
          w_next_idx   = '0;
        end else if (r_idx == IDX_LAST) begin
          w_next_state = S_RELEASE;
          w_next_idx   = '0;
        end else begin
          w_next_idx = r_idx + 4'd1;
        end
      end
      S_RELEASE: begin
        w_next_offset = (r_offset == OFF_LAST) ? 5'd0 : r_offset + 5'd1;
        w_next_cnt    = '0;
        w_next_state  = enable ? S_WAIT_TICK : S_IDLE;
      end
      S_WAIT_TICK: begin
        if (!enable) begin
          w_next_state = S_IDLE;
          w_next_cnt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = S_REQ;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // io_* decode only registered state, so bus_gnt never reaches them directly.
  always_comb begin
    io_read_en = 1'b1;
    io_addr    = 8'd0;
    io_din     = 8'd0;
    if (r_state == S_WRITE) begin
      io_read_en = 1'b0;
      io_addr    = {4'b0000, r_idx};
      io_din     = (r_idx == IDX_LAST) ? {3'b000, r_offset} : w_rdata;
    end
  end

  assign bus_req   = (r_state == S_REQ) || (r_state == S_WRITE);
  assign busy      = (r_state != S_IDLE) && (r_state != S_WAIT_TICK);
  assign offset    = r_offset;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_io_scroll_sequencer.sv
// Bench for io_scroll_sequencer: a 16-char instance with short frames and a
// 2-char instance, both checked against a frame-level reference model.
module tb_io_scroll_sequencer;
  import io_page_pkg::*;

  localparam int A_LEN = 16;
  localparam int A_FT  = 4;
  localparam int B_LEN = 2;
  localparam int B_FT  = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst, a_enable, a_msg_we, a_gnt;
  logic [4:0]    a_waddr;
  logic [7:0]    a_wdata;
  logic          a_bus_req, a_io_read_en, a_busy;
  logic [7:0]    a_io_addr, a_io_din;
  logic [4:0]    a_offset;
  scroll_state_t a_state;

  logic          b_rst, b_enable, b_msg_we, b_gnt;
  logic [4:0]    b_waddr;
  logic [7:0]    b_wdata;
  logic          b_bus_req, b_io_read_en, b_busy;
  logic [7:0]    b_io_addr, b_io_din;
  logic [4:0]    b_offset;
  scroll_state_t b_state;

  io_scroll_sequencer #(.MSG_LEN(A_LEN), .FRAME_TICKS(A_FT)) dut_a (
    .clk(clk), .rst(a_rst), .enable(a_enable), .msg_we(a_msg_we),
    .msg_waddr(a_waddr), .msg_wdata(a_wdata), .bus_req(a_bus_req),
    .bus_gnt(a_gnt), .io_addr(a_io_addr), .io_din(a_io_din),
    .io_read_en(a_io_read_en), .busy(a_busy), .offset(a_offset),
    .dbg_state(a_state)
  );

  io_scroll_sequencer #(.MSG_LEN(B_LEN), .FRAME_TICKS(B_FT)) dut_b (
    .clk(clk), .rst(b_rst), .enable(b_enable), .msg_we(b_msg_we),
    .msg_waddr(b_waddr), .msg_wdata(b_wdata), .bus_req(b_bus_req),
    .bus_gnt(b_gnt), .io_addr(b_io_addr), .io_din(b_io_din),
    .io_read_en(b_io_read_en), .busy(b_busy), .offset(b_offset),
    .dbg_state(b_state)
  );

  // scoreboard / reference model
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  a_msg[A_LEN];
  int          a_off = 0;
  logic [7:0]  b_msg[B_LEN];
  int          b_off = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected burst for the current offset: digit d shows msg[(off+7-d) mod len].
  task automatic build_frame();
    exp_q.delete();
    for (int d = 0; d < 8; d++) exp_q.push_back({8'(d), a_msg[(a_off + 7 - d) % A_LEN]});
    exp_q.push_back({8'd8, 8'(a_off)});
  endtask

  // driver tasks
  task automatic a_write(input int addr, input int data);
    a_msg_we = 1'b1;
    a_waddr  = addr[4:0];
    a_wdata  = data[7:0];
    @(negedge clk);
    a_msg_we = 1'b0;
    if (addr < A_LEN) a_msg[addr] = data[7:0];
  endtask

  task automatic b_write(input int addr, input int data);
    b_msg_we = 1'b1;
    b_waddr  = addr[4:0];
    b_wdata  = data[7:0];
    @(negedge clk);
    b_msg_we = 1'b0;
    if (addr < B_LEN) b_msg[addr] = data[7:0];
  endtask

  // One frame on instance A. Entered at a negedge; leaves at the negedge of
  // the release cycle. exp_gap<0 skips the idle-gap check.
  task automatic a_frame(input int exp_gap, input int delay, input int abort_at, input bit drop_en);
    int          cnt;
    int          busy_cnt;
    bit          aborted;
    logic [15:0] e;
    cnt = 0;
    @(negedge clk);
    while (!a_bus_req && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("bus_req_seen", a_bus_req, 1);
    if (exp_gap >= 0) check("idle_gap", cnt, exp_gap);
    busy_cnt = 0;
    for (int attempt = 0; attempt < 2; attempt++) begin
      for (int d = 0; d < delay; d++) begin
        check("req_hold", a_bus_req, 1);
        check("req_idle_rd", a_io_read_en, 1);
        busy_cnt += int'(a_busy);
        @(negedge clk);
      end
      busy_cnt += int'(a_busy);
      a_gnt = 1'b1;
      @(negedge clk);
      build_frame();
      aborted = 1'b0;
      for (int k = 0; k < 9; k++) begin
        e = exp_q.pop_front();
        if (k == 0) check("offset_port", a_offset, a_off);
        check("wr_en", a_io_read_en, 0);
        check("wr_addr", a_io_addr, e[15:8]);
        check("wr_data", a_io_din, e[7:0]);
        busy_cnt += int'(a_busy);
        if (drop_en && k == 2) a_enable = 1'b0;
        if (attempt == 0 && k == abort_at) begin
          a_gnt   = 1'b0;
          aborted = 1'b1;
          @(negedge clk);
          break;
        end
        @(negedge clk);
      end
      if (!aborted) break;
      check("abort_idle", a_io_read_en, 1);
      check("abort_addr", a_io_addr, 0);
      check("abort_req", a_bus_req, 1);
    end
    check("rel_req", a_bus_req, 0);
    check("rel_busy", a_busy, 1);
    busy_cnt += int'(a_busy);
    if (abort_at < 0) check("busy_len", busy_cnt, delay + 11);
    a_gnt = 1'b0;
    a_off = (a_off + 1) % A_LEN;
  endtask

  initial begin
    int cnt;
    int b_k;
    int b_frames;
    int nfr;
    logic [7:0] bd;

    a_rst = 1'b1; a_enable = 1'b0; a_msg_we = 1'b0; a_gnt = 1'b0;
    a_waddr = '0; a_wdata = '0;
    b_rst = 1'b1; b_enable = 1'b0; b_msg_we = 1'b0; b_gnt = 1'b0;
    b_waddr = '0; b_wdata = '0;
    for (int i = 0; i < A_LEN; i++) a_msg[i] = 8'd0;
    for (int i = 0; i < B_LEN; i++) b_msg[i] = 8'd0;
    repeat (3) @(negedge clk);
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_bus_req", a_bus_req, 0);
    check("rst_busy", a_busy, 0);
    check("rst_io_read_en", a_io_read_en, 1);
    check("rst_io_addr", a_io_addr, 0);
    check("rst_io_din", a_io_din, 0);
    check("rst_offset", a_offset, 0);
    check("rst_state", a_state, S_IDLE);

    // two-character message: offsets alternate, digits alternate
    b_write(0, 16);
    b_write(1, 17);
    b_write(5, 3);
    b_enable = 1'b1;
    b_k = 0;
    b_frames = 0;
    for (int c = 0; c < 200 && b_frames < 4; c++) begin
      @(negedge clk);
      b_gnt = b_bus_req;
      if (!b_io_read_en) begin
        bd = (b_k < 8) ? b_msg[(b_off + 7 - b_k) % B_LEN] : 8'(b_off);
        check("b_addr", b_io_addr, b_k);
        check("b_data", b_io_din, bd);
        b_k++;
        if (b_k == 9) begin
          b_k = 0;
          b_off = (b_off + 1) % B_LEN;
          b_frames++;
        end
      end
    end
    check("b_frames", b_frames, 4);
    b_enable = 1'b0;
    b_gnt = 1'b0;

    // ramp message, immediate grant, 17 frames so the offset wraps
    for (int i = 0; i < A_LEN; i++) a_write(i, i);
    a_write(20, 8'h55);
    a_enable = 1'b1;
    a_frame(0, 0, -1, 1'b0);
    for (int i = 1; i <= 16; i++) a_frame(A_FT, 0, -1, 1'b0);

    // held-off grant, then grant lost mid-burst
    a_frame(A_FT, 20, -1, 1'b0);
    a_frame(A_FT, 2, 4, 1'b0);

    // enable dropped during WRITE: burst completes, then idle
    a_frame(A_FT, 0, -1, 1'b1);
    repeat (5) @(negedge clk);
    check("drop_en_req", a_bus_req, 0);
    check("drop_en_busy", a_busy, 0);
    check("drop_en_off", a_offset, a_off);

    // enable dropped while requesting
    a_enable = 1'b1;
    @(negedge clk);
    check("req_up", a_bus_req, 1);
    a_enable = 1'b0;
    @(negedge clk);
    check("req_abandon", a_bus_req, 0);

    // enable dropped while waiting keeps the offset
    a_enable = 1'b1;
    a_frame(0, 0, -1, 1'b0);
    @(negedge clk);
    a_enable = 1'b0;
    repeat (6) @(negedge clk);
    check("wait_idle_req", a_bus_req, 0);
    check("wait_idle_busy", a_busy, 0);
    check("wait_idle_off", a_offset, a_off);

    // random message contents, grant delays and aborts
    for (int i = 0; i < 24; i++) a_write($urandom_range(0, 31), $urandom_range(0, 255));
    a_enable = 1'b1;
    nfr = $urandom_range(8, 14);
    for (int i = 0; i < nfr; i++) begin
      a_frame((i == 0) ? 0 : A_FT, $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1, 1'b0);
    end
    if (a_off == 0) a_frame(A_FT, 0, -1, 1'b0);

    // asynchronous reset in the middle of a burst
    cnt = 0;
    @(negedge clk);
    while (!a_bus_req && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check("pre_rst_req", a_bus_req, 1);
    a_gnt = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!(a_io_read_en == 1'b0 && a_io_addr == 8'd3) && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("pre_rst_idx3", a_io_addr, 3);
    a_rst = 1'b1;
    #1;
    check("mid_rst_read_en", a_io_read_en, 1);
    check("mid_rst_addr", a_io_addr, 0);
    check("mid_rst_din", a_io_din, 0);
    check("mid_rst_req", a_bus_req, 0);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_off", a_offset, 0);
    a_off = 0;
    for (int i = 0; i < A_LEN; i++) a_msg[i] = 8'd0;
    a_gnt = 1'b0;
    @(negedge clk);
    a_rst = 1'b0;
    a_frame(0, 0, -1, 1'b0);
    a_frame(A_FT, 1, -1, 1'b0);
    a_enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
